// File: rtl/fetch_stage.sv
// IF stage: owns the PC, reads combinational instruction memory, and feeds an
// IF/ID register with a valid/ready handshake toward decode.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 9,
  parameter int unsigned       INST_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  input  logic              resume,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus2,
  output logic              halted,
  output logic              align_err,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

  localparam logic [ADDR_W-1:0] PcInit = {RESET_PC[ADDR_W-1:1], 1'b0};
  localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(2);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               id_valid_q, id_valid_d;
  logic [INST_W-1:0]  id_inst_q, id_inst_d;
  logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
  logic [ADDR_W-1:0]  id_pc_plus2_q, id_pc_plus2_d;
  logic               align_err_q, align_err_d;
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic redirect_take;
  logic fetch_fire;
  logic drain;

  always_comb begin
    redirect_take = redirect_valid && (state_q != StBoot);
    fetch_fire    = (state_q == StRun) && !halt && !redirect_valid &&
                    (!id_valid_q || id_ready);
    drain         = id_valid_q && id_ready && !fetch_fire;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:   state_d = StRun;
      StRun:    if (halt) state_d = StHalted;
      StHalted: if (resume && !halt) state_d = StRun;
      default:  state_d = StBoot;
    endcase
  end

  // Redirect flushes and wins over both fetch and stall; drain only empties the register.
  always_comb begin
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_inst_d     = id_inst_q;
    id_pc_d       = id_pc_q;
    id_pc_plus2_d = id_pc_plus2_q;
    align_err_d   = align_err_q;
    fetch_count_d = fetch_count_q;
    if (redirect_take) begin
      pc_d        = {redirect_pc[ADDR_W-1:1], 1'b0};
      id_valid_d  = 1'b0;
      id_inst_d   = NOP_INST;
      align_err_d = align_err_q | redirect_pc[0];
    end else if (fetch_fire) begin
      pc_d          = pc_q + PcStep;
      id_valid_d    = 1'b1;
      id_inst_d     = imem_inst;
      id_pc_d       = pc_q;
      id_pc_plus2_d = pc_q + PcStep;
      if (fetch_count_q != '1) fetch_count_d = fetch_count_q + CNT_W'(1);
    end else if (drain) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StBoot;
      pc_q          <= PcInit;
      id_valid_q    <= 1'b0;
      id_inst_q     <= NOP_INST;
      id_pc_q       <= '0;
      id_pc_plus2_q <= '0;
      align_err_q   <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_inst_q     <= id_inst_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus2_q <= id_pc_plus2_d;
      align_err_q   <= align_err_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  always_comb begin
    imem_addr   = pc_q;
    id_valid    = id_valid_q;
    id_inst     = id_inst_q;
    id_pc       = id_pc_q;
    id_pc_plus2 = id_pc_plus2_q;
    halted      = (state_q == StHalted);
    align_err   = align_err_q;
    fetch_count = fetch_count_q;
  end

endmodule
